sr_jk_ff_bank: RTL

Parametrised multi-bit storage bank that generalises the single-bit SR flip-flop. Each of WIDTH channels stores one bit and updates every enabled clock edge according to a runtime-selected mode: SR, JK, D or T. The block adds a defined policy for the SR S=R=1 condition, per-channel conflict reporting, and a saturating conflict counter with sticky error. It is intended as a general control/status register primitive for the FlipFlops project family.

---
 rtl/sr_jk_ff_bank.sv | 103 ++++++++++
 1 files changed

// File: rtl/sr_jk_ff_bank.sv
// Multi-channel SR/JK/D/T storage bank with a defined SR S=R=1 policy,
// per-channel conflict flags, a saturating conflict counter and a sticky error.
module sr_jk_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               SR_POLICY = 0,
    parameter int               CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] conflict,
    output logic             err_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [1:0]       MODE_SR = 2'b00;
    localparam logic [1:0]       MODE_JK = 2'b01;
    localparam logic [1:0]       MODE_D  = 2'b10;
    localparam logic [1:0]       MODE_T  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_conflict;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_conf_vec;
    logic             w_any_conf;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_err_next;

    assign w_conf_vec = (mode == MODE_SR) ? (a & b) : {WIDTH{1'b0}};
    assign w_any_conf = en & (|w_conf_vec);

    always_comb begin
        w_q_next = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (mode)
                MODE_SR: begin
                    unique case ({a[i], b[i]})
                        2'b00: w_q_next[i] = r_q[i];
                        2'b01: w_q_next[i] = 1'b0;
                        2'b10: w_q_next[i] = 1'b1;
                        default: begin
                            // S=R=1: resolved by policy so q is never undefined
                            if (SR_POLICY == 1)      w_q_next[i] = 1'b0;
                            else if (SR_POLICY == 2) w_q_next[i] = 1'b1;
                            else                     w_q_next[i] = r_q[i];
                        end
                    endcase
                end
                MODE_JK: begin
                    unique case ({a[i], b[i]})
                        2'b00:   w_q_next[i] = r_q[i];
                        2'b01:   w_q_next[i] = 1'b0;
                        2'b10:   w_q_next[i] = 1'b1;
                        default: w_q_next[i] = ~r_q[i];
                    endcase
                end
                MODE_D:  w_q_next[i] = a[i];
                MODE_T:  w_q_next[i] = r_q[i] ^ a[i];
                default: w_q_next[i] = r_q[i];
            endcase
        end
    end

    // Clear is applied before the increment so a same-cycle conflict still counts.
    assign w_cnt_base = clr_err ? {CNT_W{1'b0}} : r_cnt;
    assign w_cnt_next = (w_any_conf && (w_cnt_base != CNT_MAX)) ? w_cnt_base + 1'b1 : w_cnt_base;
    assign w_err_next = (clr_err ? 1'b0 : r_err) | w_any_conf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= RESET_VAL;
            r_conflict <= {WIDTH{1'b0}};
            r_err      <= 1'b0;
            r_cnt      <= {CNT_W{1'b0}};
        end else begin
            if (en) begin
                r_q        <= w_q_next;
                r_conflict <= w_conf_vec;
            end
            r_err <= w_err_next;
            r_cnt <= w_cnt_next;
        end
    end

    assign q            = r_q;
    assign q_bar        = ~r_q;
    assign conflict     = r_conflict;
    assign err_sticky   = r_err;
    assign conflict_cnt = r_cnt;

endmodule
